rx_demux: RTL and testbench

- Receive-side counterpart of the sub-AFU Tx multiplexer.
- Takes the single CCI-P Rx bundle from the FIU/shell and routes it to N_SUBAFUS sub-AFU Rx ports:
  - c0 read responses and c1 write responses are routed by a sub-AFU tag carried in mdata (stamped by the sub-AFU shim).
  - MMIO requests are routed by address window.
- Merges global Tx almost-full with the per-sub-AFU Tx FIFO almost-full flags exported by the Tx multiplexer.

---
 rtl/rx_demux_pkg.sv | 84 ++++++++
 rtl/rx_demux_route.sv | 26 ++
 rtl/rx_demux.sv | 146 ++++++++++++++
 tb/tb_rx_demux.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_demux_pkg.sv
// Shared types and helpers for the Rx demultiplexer and the sub-AFU shim that stamps mdata tags.
package rx_demux_pkg;

   localparam int CCIP_CLDATA_W = 512;

   typedef enum logic [3:0] {eRSP_RDLINE = 4'h0, eRSP_UMSG = 4'h4} t_ccip_c0_rsp;
   typedef enum logic [3:0] {eRSP_WRLINE = 4'h0, eRSP_WRFENCE = 4'h4, eRSP_INTR = 4'h8} t_ccip_c1_rsp;

   typedef struct packed {
      logic [1:0]  vc_used;
      logic        rsvd1;
      logic        hit_miss;
      logic [1:0]  rsvd0;
      logic [1:0]  cl_num;
      logic [3:0]  resp_type;
      logic [15:0] mdata;
   } t_ccip_c0_RspMemHdr;

   // Overlays the c0 response header when an MMIO request is on the channel
   typedef struct packed {
      logic [15:0] address;
      logic [1:0]  length;
      logic        rsvd;
      logic [8:0]  tid;
   } t_ccip_c0_ReqMmioHdr;

   typedef struct packed {
      logic [1:0]  vc_used;
      logic        rsvd1;
      logic        hit_miss;
      logic        format;
      logic        rsvd0;
      logic [1:0]  cl_num;
      logic [3:0]  resp_type;
      logic [15:0] mdata;
   } t_ccip_c1_RspMemHdr;

   typedef struct packed {
      t_ccip_c0_RspMemHdr       hdr;
      logic [CCIP_CLDATA_W-1:0] data;
      logic                     rspValid;
      logic                     mmioRdValid;
      logic                     mmioWrValid;
   } t_if_ccip_c0_Rx;

   typedef struct packed {
      t_ccip_c1_RspMemHdr hdr;
      logic               rspValid;
   } t_if_ccip_c1_Rx;

   typedef struct packed {
      logic           c0TxAlmFull;
      logic           c1TxAlmFull;
      t_if_ccip_c0_Rx c0;
      t_if_ccip_c1_Rx c1;
   } t_if_ccip_Rx;

   // drop_cnt is block-global and appears identically in every port entry
   typedef struct packed {
      logic [31:0] rsp_cnt_c0;
      logic [31:0] rsp_cnt_c1;
      logic [31:0] mmio_cnt;
      logic [31:0] drop_cnt;
   } t_rx_demux_stats;

   function automatic int logn(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic [15:0] tag_extract(input logic [15:0] mdata, input int msb, input int w);
      return (mdata >> (msb - w + 1)) & ((16'd1 << w) - 16'd1);
   endfunction

   function automatic logic [15:0] sel_extract(input logic [15:0] addr, input int lsb, input int w);
      return (addr >> lsb) & ((16'd1 << w) - 16'd1);
   endfunction

   function automatic logic [31:0] sat_add(input logic [31:0] c, input logic [1:0] inc);
      logic [32:0] s;
      s = {1'b0, c} + {31'b0, inc};
      return s[32] ? 32'hFFFF_FFFF : s[31:0];
   endfunction

endpackage

// File: rtl/rx_demux_route.sv
// Single-channel tag decoder: one-hot port select from the mdata tag, with optional tag strip.
module rx_demux_route
   import rx_demux_pkg::*;
#(
   parameter int N_SUBAFUS = 16,
   parameter int TAG_MSB   = 15,
   parameter int TAG_STRIP = 1
)(
   input  logic                 i_valid,
   input  logic [15:0]          i_mdata,
   output logic [N_SUBAFUS-1:0] o_hit,
   output logic [15:0]          o_mdata
);
   localparam int          LOGN     = logn(N_SUBAFUS);
   localparam logic [15:0] TAG_MASK = ((16'd1 << LOGN) - 16'd1) << (TAG_MSB - LOGN + 1);

   logic [15:0] w_tag;

   assign w_tag   = tag_extract(i_mdata, TAG_MSB, LOGN);
   assign o_mdata = (TAG_STRIP != 0) ? (i_mdata & ~TAG_MASK) : i_mdata;

   // Tags beyond N_SUBAFUS match no port, so the beat simply falls away
   for (genvar i = 0; i < N_SUBAFUS; i++) begin : g_hit
      assign o_hit[i] = i_valid && (w_tag == 16'(i));
   end
endmodule

// File: rtl/rx_demux.sv
// CCI-P Rx demultiplexer: routes responses by mdata tag and MMIO by address window, 2-cycle latency.
// Optional RX_DEMUX_STATS_EN adds per-port saturating delivery counters on port 'stats'.
module rx_demux
   import rx_demux_pkg::*;
#(
   parameter int N_SUBAFUS     = 16,
   parameter int MDATA_TAG_MSB = 15,
   parameter int MMIO_SEL_LSB  = 10,
   parameter int TAG_STRIP     = 1
)(
   input  logic                               clk,
   input  logic                               Resetb,
   input  t_if_ccip_Rx                        in,
   input  logic [N_SUBAFUS-1:0]               c0_almFull,
   input  logic [N_SUBAFUS-1:0]               c1_almFull,
   output t_if_ccip_Rx [N_SUBAFUS-1:0]        out,
   output logic                               err_mmio_oob
`ifdef RX_DEMUX_STATS_EN
   ,output t_rx_demux_stats [N_SUBAFUS-1:0]   stats
`endif
);
   localparam int          LOGN     = logn(N_SUBAFUS);
   localparam logic [15:0] WIN_MASK = (16'd1 << MMIO_SEL_LSB) - 16'd1;

   logic [1:0]            r_rst_sync;
   logic                  w_rst_n;
   t_if_ccip_Rx           r_in;
   logic [N_SUBAFUS-1:0]  r_c0_af, r_c1_af;
   logic [N_SUBAFUS-1:0]  w_c0_hit, w_c1_hit;
   logic [15:0]           w_c0_mdata, w_c1_mdata, w_sel;
   logic                  w_c0_vld, w_mmio_vld, w_mmio_go, w_mmio_err;
   t_ccip_c0_ReqMmioHdr   w_mmio_raw, w_mmio_hdr;
   t_ccip_c0_RspMemHdr    w_c0_hdr;
   t_ccip_c1_RspMemHdr    w_c1_hdr;

   // Assert immediately, release on the second clock after Resetb rises
   always_ff @(posedge clk or negedge Resetb)
      if (!Resetb) r_rst_sync <= '0;
      else         r_rst_sync <= {r_rst_sync[0], 1'b1};
   assign w_rst_n = r_rst_sync[1];

   // T0
   always_ff @(posedge clk or negedge w_rst_n)
      if (!w_rst_n) begin
         r_in    <= '0;
         r_c0_af <= '1;
         r_c1_af <= '1;
      end else begin
         r_in    <= in;
         r_c0_af <= c0_almFull;
         r_c1_af <= c1_almFull;
      end

   assign w_c0_vld = r_in.c0.rspValid && (r_in.c0.hdr.resp_type != eRSP_UMSG);

   rx_demux_route #(.N_SUBAFUS(N_SUBAFUS), .TAG_MSB(MDATA_TAG_MSB), .TAG_STRIP(TAG_STRIP)) u_route_c0 (
      .i_valid (w_c0_vld),
      .i_mdata (r_in.c0.hdr.mdata),
      .o_hit   (w_c0_hit),
      .o_mdata (w_c0_mdata)
   );

   rx_demux_route #(.N_SUBAFUS(N_SUBAFUS), .TAG_MSB(MDATA_TAG_MSB), .TAG_STRIP(TAG_STRIP)) u_route_c1 (
      .i_valid (r_in.c1.rspValid),
      .i_mdata (r_in.c1.hdr.mdata),
      .o_hit   (w_c1_hit),
      .o_mdata (w_c1_mdata)
   );

   // A response sharing the cycle with MMIO wins; the MMIO is dropped and flagged
   assign w_mmio_raw = t_ccip_c0_ReqMmioHdr'(r_in.c0.hdr);
   assign w_sel      = sel_extract(w_mmio_raw.address, MMIO_SEL_LSB, LOGN);
   assign w_mmio_vld = r_in.c0.mmioRdValid || r_in.c0.mmioWrValid;
   assign w_mmio_go  = w_mmio_vld && !r_in.c0.rspValid && (w_sel < 16'(N_SUBAFUS));
   assign w_mmio_err = w_mmio_vld && !w_mmio_go;

   // Headers and data are broadcast; only the valids are steered
   always_comb begin
      w_mmio_hdr         = w_mmio_raw;
      w_mmio_hdr.address = w_mmio_raw.address & WIN_MASK;
      w_c0_hdr           = r_in.c0.hdr;
      w_c0_hdr.mdata     = w_c0_mdata;
      if (!r_in.c0.rspValid) w_c0_hdr = t_ccip_c0_RspMemHdr'(w_mmio_hdr);
      w_c1_hdr           = r_in.c1.hdr;
      w_c1_hdr.mdata     = w_c1_mdata;
   end

   // T1
   always_ff @(posedge clk or negedge w_rst_n)
      if (!w_rst_n) begin
         err_mmio_oob <= 1'b0;
         for (int i = 0; i < N_SUBAFUS; i++) begin
            out[i]             <= '0;
            out[i].c0TxAlmFull <= 1'b1;
            out[i].c1TxAlmFull <= 1'b1;
         end
      end else begin
         if (w_mmio_err) err_mmio_oob <= 1'b1;
         for (int i = 0; i < N_SUBAFUS; i++) begin
            out[i].c0TxAlmFull    <= r_in.c0TxAlmFull | r_c0_af[i];
            out[i].c1TxAlmFull    <= r_in.c1TxAlmFull | r_c1_af[i];
            out[i].c0.hdr         <= w_c0_hdr;
            out[i].c0.data        <= r_in.c0.data;
            out[i].c0.rspValid    <= w_c0_hit[i];
            out[i].c0.mmioRdValid <= w_mmio_go && r_in.c0.mmioRdValid && (w_sel == 16'(i));
            out[i].c0.mmioWrValid <= w_mmio_go && r_in.c0.mmioWrValid && (w_sel == 16'(i));
            out[i].c1.hdr         <= w_c1_hdr;
            out[i].c1.rspValid    <= w_c1_hit[i];
         end
      end

`ifdef RX_DEMUX_STATS_EN
   logic [N_SUBAFUS-1:0][31:0] r_c0_cnt, r_c1_cnt, r_mmio_cnt;
   logic [31:0]                r_drop_cnt;
   logic [1:0]                 w_drop_inc;

   assign w_drop_inc = 2'(r_in.c0.rspValid && !(|w_c0_hit)) +
                       2'(r_in.c1.rspValid && !(|w_c1_hit)) + 2'(w_mmio_err);

   always_ff @(posedge clk or negedge w_rst_n)
      if (!w_rst_n) begin
         r_c0_cnt   <= '0;
         r_c1_cnt   <= '0;
         r_mmio_cnt <= '0;
         r_drop_cnt <= '0;
      end else begin
         r_drop_cnt <= sat_add(r_drop_cnt, w_drop_inc);
         for (int i = 0; i < N_SUBAFUS; i++) begin
            r_c0_cnt[i]   <= sat_add(r_c0_cnt[i], {1'b0, w_c0_hit[i]});
            r_c1_cnt[i]   <= sat_add(r_c1_cnt[i], {1'b0, w_c1_hit[i]});
            r_mmio_cnt[i] <= sat_add(r_mmio_cnt[i], {1'b0, w_mmio_go && (w_sel == 16'(i))});
         end
      end

   always_comb begin
      stats = '0;
      for (int i = 0; i < N_SUBAFUS; i++) begin
         stats[i].rsp_cnt_c0 = r_c0_cnt[i];
         stats[i].rsp_cnt_c1 = r_c1_cnt[i];
         stats[i].mmio_cnt   = r_mmio_cnt[i];
         stats[i].drop_cnt   = r_drop_cnt;
      end
   end
`endif

endmodule

// File: tb/tb_rx_demux.sv
// Scoreboard bench for rx_demux: directed beats push expectations, a negedge monitor pops and compares.
module tb_rx_demux;
   import rx_demux_pkg::*;

   localparam int N   = 16;
   localparam int N12 = 12;

   logic clk = 1'b0;
   logic Resetb = 1'b1;
   t_if_ccip_Rx in, in12;
   logic [N-1:0]   c0_af, c1_af;
   logic [N12-1:0] c0_af12, c1_af12;
   t_if_ccip_Rx [N-1:0]   out;
   t_if_ccip_Rx [N12-1:0] out12;
   logic err, err12;
`ifdef RX_DEMUX_STATS_EN
   t_rx_demux_stats [N-1:0]   stats;
   t_rx_demux_stats [N12-1:0] stats12;
`endif

   rx_demux #(.N_SUBAFUS(N)) dut (
      .clk(clk), .Resetb(Resetb), .in(in), .c0_almFull(c0_af), .c1_almFull(c1_af),
      .out(out), .err_mmio_oob(err)
`ifdef RX_DEMUX_STATS_EN
      , .stats(stats)
`endif
   );

   rx_demux #(.N_SUBAFUS(N12)) dut12 (
      .clk(clk), .Resetb(Resetb), .in(in12), .c0_almFull(c0_af12), .c1_almFull(c1_af12),
      .out(out12), .err_mmio_oob(err12)
`ifdef RX_DEMUX_STATS_EN
      , .stats(stats12)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int           port;
      int           ch;     // 0 c0 rsp, 1 mmio rd, 2 mmio wr, 3 c1 rsp
      logic [27:0]  hdr;
      logic [511:0] data;
      int           cyc;
   } exp_t;

   exp_t q[$];
   int nchk = 0;
   int nerr = 0;

   function automatic t_ccip_c0_RspMemHdr mk_c0(input logic [3:0] rt, input logic [15:0] md);
      t_ccip_c0_RspMemHdr h;
      h = '0; h.vc_used = 2'b01; h.cl_num = 2'b10; h.resp_type = rt; h.mdata = md;
      return h;
   endfunction

   function automatic t_ccip_c1_RspMemHdr mk_c1(input logic [3:0] rt, input logic [15:0] md);
      t_ccip_c1_RspMemHdr h;
      h = '0; h.vc_used = 2'b10; h.hit_miss = 1'b1; h.resp_type = rt; h.mdata = md;
      return h;
   endfunction

   function automatic t_ccip_c0_ReqMmioHdr mk_mmio(input logic [15:0] a, input logic [1:0] len, input logic [8:0] tid);
      t_ccip_c0_ReqMmioHdr h;
      h = '0; h.address = a; h.length = len; h.tid = tid;
      return h;
   endfunction

   function automatic logic [N-1:0] vld_vec();
      logic [N-1:0] v;
      for (int p = 0; p < N; p++)
         v[p] = out[p].c0.rspValid | out[p].c0.mmioRdValid | out[p].c0.mmioWrValid | out[p].c1.rspValid;
      return v;
   endfunction

   function automatic logic [N12-1:0] vld_vec12();
      logic [N12-1:0] v;
      for (int p = 0; p < N12; p++)
         v[p] = out12[p].c0.rspValid | out12[p].c0.mmioRdValid | out12[p].c0.mmioWrValid | out12[p].c1.rspValid;
      return v;
   endfunction

   function automatic logic [N-1:0] af_vec(input int c);
      logic [N-1:0] v;
      for (int p = 0; p < N; p++) v[p] = (c == 0) ? out[p].c0TxAlmFull : out[p].c1TxAlmFull;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      nchk++;
      if (act !== req) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h (cyc %0d)", nm, act, req, cyc);
      end
   endtask

   task automatic push_exp(input int p, input int ch, input logic [27:0] h, input logic [511:0] d);
      exp_t e;
      e.port = p; e.ch = ch; e.hdr = h; e.data = d; e.cyc = cyc + 2;
      q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in.c0.rspValid = 1'b0; in.c0.mmioRdValid = 1'b0; in.c0.mmioWrValid = 1'b0; in.c1.rspValid = 1'b0;
      in12.c0.rspValid = 1'b0; in12.c0.mmioRdValid = 1'b0; in12.c0.mmioWrValid = 1'b0; in12.c1.rspValid = 1'b0;
   endtask

   // Monitor: every valid on the main DUT must match the head of the queue, in port/channel order
   exp_t         m_e;
   logic         m_v;
   logic [27:0]  m_h;
   logic [511:0] m_d;
   always @(negedge clk) begin
      for (int p = 0; p < N; p++) begin
         for (int c = 0; c < 4; c++) begin
            case (c)
               0:       begin m_v = out[p].c0.rspValid;    m_h = out[p].c0.hdr; m_d = out[p].c0.data; end
               1:       begin m_v = out[p].c0.mmioRdValid; m_h = out[p].c0.hdr; m_d = out[p].c0.data; end
               2:       begin m_v = out[p].c0.mmioWrValid; m_h = out[p].c0.hdr; m_d = out[p].c0.data; end
               default: begin m_v = out[p].c1.rspValid;    m_h = out[p].c1.hdr; m_d = '0; end
            endcase
            if (m_v) begin
               nchk++;
               if (q.size() == 0) begin
                  nerr++;
                  $display("FAIL sb_unexpected: port %0d ch %0d valid at cyc %0d, expected no output", p, c, cyc);
               end else begin
                  m_e = q.pop_front();
                  if (m_e.port != p || m_e.ch != c || m_e.hdr !== m_h || m_e.data !== m_d || m_e.cyc != cyc) begin
                     nerr++;
                     $display("FAIL sb_beat: got port %0d ch %0d hdr %h data %h cyc %0d, expected port %0d ch %0d hdr %h data %h cyc %0d",
                              p, c, m_h, m_d[63:0], cyc, m_e.port, m_e.ch, m_e.hdr, m_e.data[63:0], m_e.cyc);
                  end
               end
            end
         end
      end
   end

   initial begin
      in = '0; in12 = '0; c0_af = '0; c1_af = '0; c0_af12 = '0; c1_af12 = '0;
      #1 Resetb = 1'b0;
      repeat (3) tick();

      chk("rst_valid",  32'(vld_vec()), 32'h0);
      chk("rst_af0",    32'(af_vec(0)), 32'hFFFF);
      chk("rst_af1",    32'(af_vec(1)), 32'hFFFF);
      chk("rst_err",    32'(err), 32'h0);

      // Release; a beat presented after the second edge must be delivered
      Resetb = 1'b1;
      tick();
      tick();
      in.c0.hdr = mk_c0(eRSP_RDLINE, 16'h2042); in.c0.data = 512'h1111; in.c0.rspValid = 1'b1;
      push_exp(2, 0, mk_c0(eRSP_RDLINE, 16'h0042), 512'h1111);
      tick(); idle(); tick();

      // Tag 10 with strip
      in.c0.hdr = mk_c0(eRSP_RDLINE, 16'hA123); in.c0.data = 512'hDEAD_BEEF_CAFE; in.c0.rspValid = 1'b1;
      push_exp(10, 0, mk_c0(eRSP_RDLINE, 16'h0123), 512'hDEAD_BEEF_CAFE);
      tick(); idle(); tick();

      // c0 and c1 to the same port, then to different ports, then fence/interrupt
      in.c0.hdr = mk_c0(eRSP_RDLINE, 16'h3055); in.c0.data = 512'h33; in.c0.rspValid = 1'b1;
      in.c1.hdr = mk_c1(eRSP_WRLINE, 16'h3077); in.c1.rspValid = 1'b1;
      push_exp(3, 0, mk_c0(eRSP_RDLINE, 16'h0055), 512'h33);
      push_exp(3, 3, mk_c1(eRSP_WRLINE, 16'h0077), '0);
      tick();
      in.c0.hdr = mk_c0(eRSP_RDLINE, 16'h3066); in.c0.data = 512'h34;
      in.c1.hdr = mk_c1(eRSP_WRFENCE, 16'h7001);
      push_exp(3, 0, mk_c0(eRSP_RDLINE, 16'h0066), 512'h34);
      push_exp(7, 3, mk_c1(eRSP_WRFENCE, 16'h0001), '0);
      tick();
      in.c0.rspValid = 1'b0;
      in.c1.hdr = mk_c1(eRSP_INTR, 16'hC00F);
      push_exp(12, 3, mk_c1(eRSP_INTR, 16'h000F), '0);
      tick(); idle();

      // UMSG is dropped silently
      in.c0.hdr = mk_c0(eRSP_UMSG, 16'h5000); in.c0.data = 512'h77; in.c0.rspValid = 1'b1;
      tick(); idle(); tick();

      // MMIO write and read, window-relative address
      in.c0.hdr = t_ccip_c0_RspMemHdr'(mk_mmio(16'h2C10, 2'b01, 9'h1A5)); in.c0.data = 512'h0123_4567_89AB_CDEF;
      in.c0.mmioWrValid = 1'b1;
      push_exp(11, 2, mk_mmio(16'h0010, 2'b01, 9'h1A5), 512'h0123_4567_89AB_CDEF);
      tick(); idle();
      in.c0.hdr = t_ccip_c0_RspMemHdr'(mk_mmio(16'h0404, 2'b00, 9'h033)); in.c0.data = '0;
      in.c0.mmioRdValid = 1'b1;
      push_exp(1, 1, mk_mmio(16'h0004, 2'b00, 9'h033), '0);
      tick(); idle(); tick(); tick();
      chk("mmio_ok_err", 32'(err), 32'h0);

      // almFull merge, exact 2-cycle latency
      c0_af[5] = 1'b1; c1_af[9] = 1'b1;
      tick();
      chk("af0_lat1", 32'(af_vec(0)), 32'h0);
      tick();
      chk("af0_port5", 32'(af_vec(0)), 32'h0020);
      chk("af1_port9", 32'(af_vec(1)), 32'h0200);
      in.c0TxAlmFull = 1'b1; c0_af = '0; c1_af = '0;
      tick(); tick();
      chk("af0_global", 32'(af_vec(0)), 32'hFFFF);
      chk("af1_clear",  32'(af_vec(1)), 32'h0);
      in.c0TxAlmFull = 1'b0;
      tick(); tick();
      chk("af0_clear", 32'(af_vec(0)), 32'h0);

      // Response + MMIO collision: response delivered, MMIO flagged
      in.c0.hdr = mk_c0(eRSP_RDLINE, 16'h4ABC); in.c0.data = 512'h55;
      in.c0.rspValid = 1'b1; in.c0.mmioWrValid = 1'b1;
      push_exp(4, 0, mk_c0(eRSP_RDLINE, 16'h0ABC), 512'h55);
      tick(); idle(); tick();
      chk("collide_err", 32'(err), 32'h1);
      tick(); tick();
      chk("collide_sticky", 32'(err), 32'h1);

      // Reset mid-stream: a beat already in T0 must not come out
      in.c0.hdr = mk_c0(eRSP_RDLINE, 16'h6001); in.c0.data = 512'h66; in.c0.rspValid = 1'b1;
      tick(); idle();
      Resetb = 1'b0;
      #1;
      chk("midrst_valid", 32'(vld_vec()), 32'h0);
      chk("midrst_af0",   32'(af_vec(0)), 32'hFFFF);
      chk("midrst_err",   32'(err), 32'h0);
      repeat (3) tick();
      Resetb = 1'b1;
      repeat (3) tick();

      // 100 back-to-back responses round-robin over all tags
      for (int i = 0; i < 100; i++) begin
         in.c0.hdr = mk_c0(eRSP_RDLINE, {4'(i % 16), 12'(i)}); in.c0.data = 512'(i + 1000); in.c0.rspValid = 1'b1;
         push_exp(i % 16, 0, mk_c0(eRSP_RDLINE, {4'h0, 12'(i)}), 512'(i + 1000));
         tick();
      end
      idle();
      repeat (4) tick();
`ifdef RX_DEMUX_STATS_EN
      for (int p = 0; p < N; p++) chk($sformatf("stats_c0_%0d", p), stats[p].rsp_cnt_c0, (p < 4) ? 32'd7 : 32'd6);
      chk("stats_drop", stats[0].drop_cnt, 32'd0);
`endif

      // N=12 instance: out-of-range tag dropped without error
      in12.c0.hdr = mk_c0(eRSP_RDLINE, 16'hD000); in12.c0.rspValid = 1'b1;
      tick(); idle(); tick();
      chk("n12_tagoob_valid", 32'(vld_vec12()), 32'h0);
      chk("n12_tagoob_err",   32'(err12), 32'h0);

      in12.c0.hdr = t_ccip_c0_RspMemHdr'(mk_mmio(16'h0810, 2'b10, 9'h005)); in12.c0.mmioWrValid = 1'b1;
      tick(); idle(); tick();
      chk("n12_mmio_valid", 32'(vld_vec12()), 32'h004);
      chk("n12_mmio_hdr",   32'(out12[2].c0.hdr), 32'(mk_mmio(16'h0010, 2'b10, 9'h005)));

      in12.c0.hdr = t_ccip_c0_RspMemHdr'(mk_mmio(16'h3400, 2'b00, 9'h00A)); in12.c0.mmioWrValid = 1'b1;
      tick(); idle(); tick();
      chk("n12_oob_valid", 32'(vld_vec12()), 32'h0);
      chk("n12_oob_err",   32'(err12), 32'h1);
      repeat (3) tick();
      chk("n12_oob_sticky", 32'(err12), 32'h1);

      repeat (3) tick();
      chk("sb_drained", 32'(q.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
